// File: rtl/wb_intercon_pkg.sv
// ============================================================================
//  Module  : wb_intercon_pkg
//  Brief   : Shared types and constants for the Wishbone 1-to-N interconnect.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_intercon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } mux_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    localparam int TMO_CNT_W = 16;

    // Index width that stays legal for a single-slave build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_mux_pipe_decode.sv
// ============================================================================
//  Module  : wb_mux_pipe_decode
//  Brief   : Combinational address match; lowest matching slave index wins.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_mux_pipe_decode
    import wb_intercon_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       AW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
    localparam int                      IDXW       = idx_width(NUM_SLAVES)
) (
    input  logic [AW-1:0]   adr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    logic [NUM_SLAVES-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign w_hit[gi] = ((adr & MATCH_MASK[gi*AW +: AW]) == MATCH_ADDR[gi*AW +: AW]);
        end
    endgenerate

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        valid = |w_hit;
        idx   = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_mux_pipe.sv
// ============================================================================
//  Module  : wb_mux_pipe
//  Brief   : Wishbone 1-master to N-slave mux with registered decode and
//            locked selection; optional stall timeout via WB_MUX_PIPE_TIMEOUT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_mux_pipe
    import wb_intercon_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter int                       AW             = 32,
    parameter int                       DW             = 32,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR     = {NUM_SLAVES{{AW{1'b0}}}},
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK     = {NUM_SLAVES{{AW{1'b0}}}},
    parameter int                       TIMEOUT_CYCLES = 255,
    localparam int                      SW             = DW / 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,

    input  logic [AW-1:0]              wbm_adr_i,
    input  logic [DW-1:0]              wbm_dat_i,
    input  logic [SW-1:0]              wbm_sel_i,
    input  logic                       wbm_we_i,
    input  logic                       wbm_cyc_i,
    input  logic                       wbm_stb_i,
    input  logic [2:0]                 wbm_cti_i,
    input  logic [1:0]                 wbm_bte_i,
    output logic [DW-1:0]              wbm_dat_o,
    output logic                       wbm_ack_o,
    output logic                       wbm_err_o,
    output logic                       wbm_rty_o,

    output logic [NUM_SLAVES*AW-1:0]   wbs_adr_o,
    output logic [NUM_SLAVES*DW-1:0]   wbs_dat_o,
    output logic [NUM_SLAVES*SW-1:0]   wbs_sel_o,
    output logic [NUM_SLAVES-1:0]      wbs_we_o,
    output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]      wbs_stb_o,
    output logic [NUM_SLAVES*3-1:0]    wbs_cti_o,
    output logic [NUM_SLAVES*2-1:0]    wbs_bte_o,
    input  logic [NUM_SLAVES*DW-1:0]   wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]      wbs_err_i,
    input  logic [NUM_SLAVES-1:0]      wbs_rty_i
);

    localparam int IDXW = idx_width(NUM_SLAVES);

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > 32 || (DW % 8) != 0 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
            $error("wb_mux_pipe: parameter out of range");
        end
    endgenerate

    mux_state_e             r_state, w_state_nxt;
    logic [IDXW-1:0]        r_sel, w_sel_nxt;
    logic                   w_dec_valid;
    logic [IDXW-1:0]        w_dec_idx;
    logic [NUM_SLAVES-1:0]  w_sel_oh;
    logic [DW-1:0]          w_sel_dat;
    logic                   w_sel_ack, w_sel_err, w_sel_rty;
    logic                   w_active;
    logic                   w_timeout;

    wb_mux_pipe_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (AW),
        .MATCH_ADDR (MATCH_ADDR),
        .MATCH_MASK (MATCH_MASK)
    ) u_decode (
        .adr   (wbm_adr_i),
        .valid (w_dec_valid),
        .idx   (w_dec_idx)
    );

    assign w_active = (r_state == ST_ACTIVE);

    always_comb begin : p_resp_mux
        w_sel_oh  = '0;
        w_sel_dat = '0;
        w_sel_ack = 1'b0;
        w_sel_err = 1'b0;
        w_sel_rty = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel == IDXW'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_sel_dat   = wbs_dat_i[i*DW +: DW];
                w_sel_ack   = wbs_ack_i[i];
                w_sel_err   = wbs_err_i[i];
                w_sel_rty   = wbs_rty_i[i];
            end
        end
    end

`ifdef WB_MUX_PIPE_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] r_tmo_cnt;
    logic                 w_stall;

    assign w_stall   = w_active && wbm_cyc_i && wbm_stb_i && !(w_sel_ack || w_sel_err || w_sel_rty);
    // Fires on the stall cycle that reaches the limit; a response in that cycle clears w_stall.
    assign w_timeout = w_stall && (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_tmo_cnt <= '0;
        end else if (w_stall && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin : p_fsm_next
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (w_dec_valid) begin
                        w_state_nxt = ST_ACTIVE;
                        w_sel_nxt   = w_dec_idx;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!wbm_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin : p_slave_ctl
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        if (w_active && !w_timeout) begin
            wbs_cyc_o = w_sel_oh & {NUM_SLAVES{wbm_cyc_i}};
            wbs_stb_o = w_sel_oh & {NUM_SLAVES{wbm_stb_i}};
        end
    end

    assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
    assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
    assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
    assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
    assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
    assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

    assign wbm_dat_o = w_active ? w_sel_dat : '0;
    assign wbm_ack_o = w_active && w_sel_ack;
    assign wbm_err_o = (w_active && w_sel_err) || (r_state == ST_ERR);
    assign wbm_rty_o = w_active && w_sel_rty;

endmodule

`default_nettype wire

// File: tb/tb_wb_mux_pipe.sv
// ============================================================================
//  Module  : tb_wb_mux_pipe
//  Brief   : Self-checking bench for wb_mux_pipe with scoreboarded responses.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_mux_pipe;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]    m_adr;
    logic [DW-1:0]    m_dat;
    logic [SW-1:0]    m_sel;
    logic             m_we, m_cyc, m_stb;
    logic [2:0]       m_cti;
    logic [1:0]       m_bte;
    logic [DW-1:0]    wbm_dat_o;
    logic             wbm_ack_o, wbm_err_o, wbm_rty_o;

    logic [NS*AW-1:0] wbs_adr_o;
    logic [NS*DW-1:0] wbs_dat_o;
    logic [NS*SW-1:0] wbs_sel_o;
    logic [NS-1:0]    wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [NS*3-1:0]  wbs_cti_o;
    logic [NS*2-1:0]  wbs_bte_o;
    logic [NS*DW-1:0] wbs_dat_i;
    logic [NS-1:0]    wbs_ack_i, wbs_err_i, wbs_rty_i;

    wb_mux_pipe #(
        .NUM_SLAVES     (NS),
        .AW             (AW),
        .DW             (DW),
        .MATCH_ADDR     ({32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000}),
        .MATCH_MASK     ({4{32'hFFFF_FF00}}),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbm_adr_i (m_adr),
        .wbm_dat_i (m_dat),
        .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),
        .wbm_cyc_i (m_cyc),
        .wbm_stb_i (m_stb),
        .wbm_cti_i (m_cti),
        .wbm_bte_i (m_bte),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i)
    );

    // Slave models: registered single-cycle response, 64-word memory each.
    logic [DW-1:0] mem [NS][64];
    logic [DW-1:0] r_dat [NS];
    logic [NS-1:0] r_ack, r_err, r_rty;
    logic [NS-1:0] stall_en, force_ack;
    logic [1:0]    resp_mode [NS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= '0;
            r_err <= '0;
            r_rty <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (wbs_cyc_o[i] && wbs_stb_o[i] && !(r_ack[i] || r_err[i] || r_rty[i]) && !stall_en[i]) begin
                    r_ack[i] <= (resp_mode[i] == 2'd0);
                    r_err[i] <= (resp_mode[i] == 2'd1);
                    r_rty[i] <= (resp_mode[i] == 2'd2);
                    r_dat[i] <= mem[i][wbs_adr_o[i*AW+2 +: 6]];
                    if (wbs_we_o[i] && resp_mode[i] == 2'd0)
                        mem[i][wbs_adr_o[i*AW+2 +: 6]] <= wbs_dat_o[i*DW +: DW];
                end else begin
                    r_ack[i] <= 1'b0;
                    r_err[i] <= 1'b0;
                    r_rty[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        wbs_dat_i = '0;
        for (int i = 0; i < NS; i++) wbs_dat_i[i*DW +: DW] = r_dat[i];
        wbs_ack_i = r_ack | force_ack;
        wbs_err_i = r_err;
        wbs_rty_i = r_rty;
    end

    typedef struct {
        logic [1:0]  kind;   // 0 ack, 1 err, 2 rty
        logic [31:0] dat;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic idle_master();
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_cti = 3'b000; m_bte = 2'b00; m_sel = 4'hF;
    endtask

    task automatic single(input string nm, input logic [31:0] adr, input logic we,
                          input logic [31:0] wdat, input logic [3:0] exp_cyc,
                          input logic [1:0] exp_kind, input logic chk_dat,
                          input logic [31:0] exp_dat, input int exp_lat);
        exp_t e, g;
        int   n;
        logic got;
        logic [1:0] kind;
        e.kind = exp_kind; e.dat = exp_dat; e.chk = chk_dat;
        sb.push_back(e);
        m_adr = adr; m_we = we; m_dat = wdat; m_sel = 4'hF; m_cti = 3'b000;
        m_cyc = 1'b1; m_stb = 1'b1;
        #1;
        checks++;
        if (wbs_cyc_o !== 4'b0000) begin
            failures++;
            $display("FAIL %s decode_latency: wbs_cyc_o=%b required 0000", nm, wbs_cyc_o);
        end
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                checks++;
                if (wbs_cyc_o !== exp_cyc) begin
                    failures++;
                    $display("FAIL %s slave_select: wbs_cyc_o=%b required %b", nm, wbs_cyc_o, exp_cyc);
                end
            end
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) got = 1'b1;
        end
        g = sb.pop_front();
        checks++;
        kind = wbm_ack_o ? 2'd0 : (wbm_err_o ? 2'd1 : 2'd2);
        if (!got || kind !== g.kind || n != exp_lat) begin
            failures++;
            $display("FAIL %s response: got=%0d kind=%0d cycles=%0d required kind=%0d cycles=%0d",
                     nm, got, kind, n, g.kind, exp_lat);
        end
        if (got && g.chk) begin
            checks++;
            if (wbm_dat_o !== g.dat) begin
                failures++;
                $display("FAIL %s read_data: got=%h required %h", nm, wbm_dat_o, g.dat);
            end
        end
        idle_master();
        @(posedge clk); #1;
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_cyc_o} !== 7'b0) begin
            failures++;
            $display("FAIL %s release: ack=%b err=%b rty=%b cyc=%b required all 0",
                     nm, wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_cyc_o);
        end
    endtask

    task automatic burst(input string nm, input logic [31:0] start, input logic we,
                         input logic [31:0] base);
        exp_t e, g;
        int   n, beat;
        logic sel_ok;
        for (int k = 0; k < 4; k++) begin
            e.kind = 2'd0; e.dat = base + k; e.chk = !we;
            sb.push_back(e);
        end
        m_adr = start; m_dat = base; m_we = we; m_sel = 4'hF; m_cti = 3'b010;
        m_cyc = 1'b1; m_stb = 1'b1;
        n = 0; beat = 0; sel_ok = 1'b1;
        while (beat < 4 && n < 40) begin
            @(posedge clk); #1; n++;
            if (wbs_cyc_o !== 4'b0010) sel_ok = 1'b0;
            if (wbm_ack_o) begin
                g = sb.pop_front();
                if (g.chk) begin
                    checks++;
                    if (wbm_dat_o !== g.dat) begin
                        failures++;
                        $display("FAIL %s beat%0d_data: got=%h required %h", nm, beat, wbm_dat_o, g.dat);
                    end
                end
                beat++;
                m_adr = start + 32'(4 * beat);
                m_dat = base + 32'(beat);
                m_cti = (beat == 3) ? 3'b111 : 3'b010;
            end
        end
        checks++;
        if (beat != 4 || !sel_ok) begin
            failures++;
            $display("FAIL %s lock: beats=%0d sel_ok=%0d required beats=4 sel_ok=1", nm, beat, sel_ok);
        end
        sb.delete();
        idle_master();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_master();
        m_adr = 32'h0000_0100; m_cyc = 1'b1; m_stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 11'b0) begin
            failures++;
            $display("FAIL reset_hold: cyc=%b stb=%b ack=%b err=%b rty=%b required all 0",
                     wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o);
        end
        idle_master();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o} !== 39'b0) begin
            failures++;
            $display("FAIL reset_idle: cyc=%b ack=%b err=%b rty=%b dat=%h required all 0",
                     wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o);
        end
    endtask

    task automatic test_classic();
        single("wr_204", 32'h0000_0204, 1'b1, 32'hDEAD_BEEF, 4'b0100, 2'd0, 1'b0, 32'h0, 2);
        single("rd_204", 32'h0000_0204, 1'b0, 32'h0,         4'b0100, 2'd0, 1'b1, 32'hDEAD_BEEF, 2);
        for (int s = 0; s < NS; s++)
            single("wr_each", 32'(s * 256 + 12), 1'b1, 32'h5A00_0000 + 32'(s), 4'(1 << s), 2'd0, 1'b0, 32'h0, 2);
        for (int s = 0; s < NS; s++)
            single("rd_each", 32'(s * 256 + 12), 1'b0, 32'h0, 4'(1 << s), 2'd0, 1'b1, 32'h5A00_0000 + 32'(s), 2);
    endtask

    task automatic test_nomatch();
        single("nomatch", 32'h0000_1000, 1'b0, 32'h0, 4'b0000, 2'd1, 1'b0, 32'h0, 1);
    endtask

    task automatic test_slave_resp();
        resp_mode[0] = 2'd1;
        single("slv_err", 32'h0000_0008, 1'b0, 32'h0, 4'b0001, 2'd1, 1'b0, 32'h0, 2);
        resp_mode[0] = 2'd2;
        single("slv_rty", 32'h0000_0008, 1'b0, 32'h0, 4'b0001, 2'd2, 1'b0, 32'h0, 2);
        resp_mode[0] = 2'd0;
    endtask

    task automatic test_burst();
        burst("burst_wr", 32'h0000_01F8, 1'b1, 32'hB000_0000);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[1][(62 + k) % 64] !== 32'hB000_0000 + 32'(k)) begin
                failures++;
                $display("FAIL burst_mem beat%0d: slave1 word=%h required %h",
                         k, mem[1][(62 + k) % 64], 32'hB000_0000 + 32'(k));
            end
        end
        checks++;
        if (mem[2][1] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL burst_s2_untouched: slave2 word1=%h required deadbeef", mem[2][1]);
        end
        burst("burst_rd", 32'h0000_01F8, 1'b0, 32'hB000_0000);
    endtask

    task automatic test_timeout();
        int   n;
        logic got, cyc_ok;
        stall_en[3] = 1'b1;
        m_adr = 32'h0000_0300; m_we = 1'b0; m_cti = 3'b000; m_cyc = 1'b1; m_stb = 1'b1;
`ifdef WB_MUX_PIPE_TIMEOUT_EN
        n = 0; got = 1'b0; cyc_ok = 1'b1;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (wbm_err_o || wbm_ack_o) got = 1'b1;
            else if (n < 16 && wbs_cyc_o !== 4'b1000) cyc_ok = 1'b0;
            else if (n == 16 && wbs_cyc_o !== 4'b0000) cyc_ok = 1'b0;
        end
        checks++;
        if (!got || !wbm_err_o || n != 17) begin
            failures++;
            $display("FAIL tmo_err: got=%0d err=%b cycle=%0d required err at cycle 17", got, wbm_err_o, n);
        end
        checks++;
        if (!cyc_ok) begin
            failures++;
            $display("FAIL tmo_cyc: slave3 cyc pattern wrong, required 1000 for 15 cycles then 0000");
        end
        idle_master();
        @(posedge clk); #1;
        checks++;
        if (wbm_err_o !== 1'b0) begin
            failures++;
            $display("FAIL tmo_err_width: err=%b required 0", wbm_err_o);
        end
        stall_en[3] = 1'b0;
        single("tmo_recover", 32'h0000_0000, 1'b1, 32'hA5A5_0000, 4'b0001, 2'd0, 1'b0, 32'h0, 2);
        stall_en[2] = 1'b1;
        m_adr = 32'h0000_0208; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        cyc_ok = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k < 16 && (wbm_err_o || wbm_ack_o)) cyc_ok = 1'b0;
        end
        force_ack[2] = 1'b1;
        #1;
        checks++;
        if (wbm_ack_o !== 1'b1 || wbm_err_o !== 1'b0 || !cyc_ok) begin
            failures++;
            $display("FAIL ack_wins: ack=%b err=%b early_resp=%0d required ack=1 err=0 early_resp=0",
                     wbm_ack_o, wbm_err_o, !cyc_ok);
        end
        idle_master();
        @(posedge clk); force_ack[2] = 1'b0; #1;
        checks++;
        if (wbm_err_o !== 1'b0) begin
            failures++;
            $display("FAIL ack_wins_noerr: err=%b required 0", wbm_err_o);
        end
        stall_en[2] = 1'b0;
`else
        cyc_ok = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (wbm_err_o || wbm_ack_o || wbs_cyc_o !== 4'b1000) cyc_ok = 1'b0;
        end
        checks++;
        if (!cyc_ok) begin
            failures++;
            $display("FAIL no_timeout: stalled access did not stay selected without response");
        end
        stall_en[3] = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk); #1; n++;
            if (wbm_ack_o) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL stall_release: ack=%b required 1 within 10 cycles", wbm_ack_o);
        end
        idle_master();
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_reset_mid();
        stall_en[1] = 1'b1;
        m_adr = 32'h0000_0104; m_we = 1'b1; m_dat = 32'hCAFE_0001; m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (wbs_cyc_o !== 4'b0010) begin
            failures++;
            $display("FAIL rst_pre: wbs_cyc_o=%b required 0010", wbs_cyc_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 11'b0) begin
            failures++;
            $display("FAIL rst_async: cyc=%b stb=%b ack=%b err=%b rty=%b required all 0",
                     wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o);
        end
        idle_master();
        stall_en[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        single("rst_wr", 32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0010, 2'd0, 1'b0, 32'h0, 2);
        single("rst_rd", 32'h0000_0100, 1'b0, 32'h0, 4'b0010, 2'd0, 1'b1, 32'h1234_5678, 2);
    endtask

    initial begin
        stall_en  = '0;
        force_ack = '0;
        for (int i = 0; i < NS; i++) resp_mode[i] = 2'd0;
        m_adr = '0; m_dat = '0;
        idle_master();
        test_reset();
        test_classic();
        test_nomatch();
        test_slave_resp();
        test_burst();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/wb_mux_pipe.md
WB_MUX_PIPE -- requirements
Module: wb_mux_pipe

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (1..32).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; byte-select width SW = DW/8.
REQ-004 SHALL have parameter MATCH_ADDR, default {NUM_SLAVES{AW'h0}}, packed per-slave base addresses, slave i in bits [i*AW +: AW].
REQ-005 SHALL have parameter MATCH_MASK, default {NUM_SLAVES{AW'h0}}, packed per-slave masks, same packing.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, stall limit in cycles (1..65535).
REQ-007 SHALL have ports, in this order (clock and reset first):
- wb_clk_i  in  1  clock, rising edge.
- wb_rst_ni  in  1  reset; one clock, reset asynchronous active-low.
- wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  AW/DW/SW/1/1/1/3/2  master request.
- wbm_dat_o/ack_o/err_o/rty_o  out  DW/1/1/1  master response.
- wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  NUM_SLAVES x (AW/DW/SW/1/1/1/3/2)  packed slave requests.
- wbs_dat_i/ack_i/err_i/rty_i  in  NUM_SLAVES x (DW/1/1/1)  packed slave responses.

Function
REQ-008 SHALL implement an FSM with states IDLE, ACTIVE, ERR.
REQ-009 Slave i SHALL match when (wbm_adr_i & MATCH_MASK[i]) == MATCH_ADDR[i]; on multiple matches the lowest index wins.
REQ-010 In IDLE with wbm_cyc_i & wbm_stb_i: match -> register slave index, go to ACTIVE; no match -> go to ERR.
REQ-011 Slave cyc/stb SHALL therefore assert exactly one cycle after the master request first appears (one-cycle decode latency).
REQ-012 In ACTIVE: wbs_cyc_o[sel] = wbm_cyc_i and wbs_stb_o[sel] = wbm_stb_i; all other slave cyc/stb bits = 0.
REQ-013 The selected slave's dat/ack/err/rty SHALL be returned to the master combinationally; the master sees 0 on these outside ACTIVE, except err in ERR.
REQ-014 adr/dat/sel/we/cti/bte SHALL be broadcast combinationally to all slave ports.
REQ-015 The selection SHALL be locked while wbm_cyc_i stays high; address changes within the cycle (bursts, cti 3'b010) SHALL NOT re-decode.
REQ-016 ACTIVE SHALL return to IDLE on the first cycle wbm_cyc_i is low.
REQ-017 ERR SHALL assert wbm_err_o for exactly one cycle, then go to IDLE; no wbs_cyc_o bit is asserted.
REQ-018 wbm_cyc_i dropping in IDLE or ERR SHALL leave no pending state.

Reset
REQ-019 wb_rst_ni low SHALL asynchronously force IDLE, clear the selection and timeout counter, and drive all wbs_cyc_o/wbs_stb_o and wbm_ack_o/err_o/rty_o to 0, including mid-transfer.
REQ-020 Reset release SHALL be sampled synchronously; the first request is accepted on the first edge after release.

Configuration
REQ-021 Macro WB_MUX_PIPE_TIMEOUT_EN defined: in ACTIVE, a 16-bit counter SHALL count cycles with stb high and no ack/err/rty from the selected slave.
- The counter clears on any termination or when stb is low.
- On reaching TIMEOUT_CYCLES the FSM goes to ERR and the selected slave's cyc/stb drop in that same cycle.
- A slave ack/err/rty in the cycle the limit is reached SHALL win; no timeout err is issued.
REQ-022 Macro undefined: no counter SHALL exist; ACTIVE waits indefinitely.

Structure
REQ-023 Package wb_intercon_pkg SHALL hold the FSM state enum, CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111), BTE constants, and the timeout counter width.
REQ-024 Sub-module wb_mux_pipe_decode SHALL perform the combinational match, returning valid plus index.

Verification (NUM_SLAVES=4, MATCH_ADDR 0x000/0x100/0x200/0x300, MATCH_MASK 0xFFFFFF00, TIMEOUT_CYCLES=16)
REQ-025 Classic write 0x204 with data 0xDEADBEEF, sel 4'hF -> wbs_cyc_o = 4'b0100 one cycle after stb; ack returned; slave 2 word 1 reads back 0xDEADBEEF.
REQ-026 Read 0x1000 (no match) -> wbs_cyc_o stays 0; wbm_err_o high for exactly one cycle, one cycle after stb.
REQ-027 INCR burst of 4 starting at 0x1F8 with cti=EOB on the last beat -> all beats go to slave 1 (wbs_cyc_o = 4'b0010); slave 2 is never selected.
REQ-028 TIMEOUT_EN defined, slave 3 never acks, access to 0x300 -> err after 16 stalled cycles and wbs_cyc_o[3] drops; next request to 0x000 completes normally.
REQ-029 TIMEOUT_EN defined, slave acks on exactly the 16th stalled cycle -> wbm_ack_o = 1 and wbm_err_o stays 0.
REQ-030 wb_rst_ni pulled low mid-ACTIVE between clock edges -> all cyc/stb/ack/err outputs 0 immediately; after release a write to 0x100 succeeds.
